fruit_launcher: RTL

Multi-slot projectile engine for the fruit game. Holds NUM_FRUITS independent fruit slots and launches each from the screen bottom with a caller-supplied velocity. Every frame it applies gravity to each fruit, checks each fruit against the blade point for a slice, and retires fruits that leave the screen. It sits between the spawn logic (launch requests) and the colour mapper (per-slot position/status), clocked once per video frame.

---
 rtl/fruit_launcher.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/fruit_launcher.sv
// Multi-slot fruit projectile engine: launch, gravity, wall bounce, blade slicing, exit.
// Optional FRUIT_PAUSE_EN adds a `pause` input that freezes the whole engine.
module fruit_launcher #(
  parameter int NUM_FRUITS = 4,
  parameter int VEL_W      = 8,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int SIZE       = 4,
  parameter int GRAVITY    = 1,
  parameter int VMAX       = 12
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
`ifdef FRUIT_PAUSE_EN
  input  logic                    pause,
`endif
  input  logic                    launch_valid,
  output logic                    launch_ready,
  input  logic [9:0]              launch_x,
  input  logic [VEL_W-1:0]        launch_vx,
  input  logic [VEL_W-1:0]        launch_vy,
  input  logic                    blade_valid,
  input  logic [9:0]              blade_x,
  input  logic [9:0]              blade_y,
  output logic [10*NUM_FRUITS-1:0] fruitX,
  output logic [10*NUM_FRUITS-1:0] fruitY,
  output logic [9:0]              fruitS,
  output logic [NUM_FRUITS-1:0]   fruit_active,
  output logic [NUM_FRUITS-1:0]   fruit_sliced,
  output logic                    slice_pulse,
  output logic                    miss_pulse,
  output logic [7:0]              hit_count,
  output logic [7:0]              miss_count
);

  typedef enum logic [1:0] {IDLE, FLYING, SLICED} slot_state_t;

  localparam logic signed [10:0] SZ  = 11'(SIZE);
  localparam logic signed [10:0] XMX = 11'(X_MAX);
  localparam logic signed [10:0] YMX = 11'(Y_MAX);
  localparam logic signed [10:0] GRV = 11'(GRAVITY);
  localparam logic signed [10:0] VMX = 11'(VMAX);

  slot_state_t             state_q [NUM_FRUITS];
  slot_state_t             state_d [NUM_FRUITS];
  logic [9:0]              x_q [NUM_FRUITS];
  logic [9:0]              x_d [NUM_FRUITS];
  logic [9:0]              y_q [NUM_FRUITS];
  logic [9:0]              y_d [NUM_FRUITS];
  logic signed [VEL_W-1:0] vx_q [NUM_FRUITS];
  logic signed [VEL_W-1:0] vx_d [NUM_FRUITS];
  logic signed [VEL_W-1:0] vy_q [NUM_FRUITS];
  logic signed [VEL_W-1:0] vy_d [NUM_FRUITS];

  logic       run;
  logic       any_idle;
  logic [2:0] launch_idx;
  logic       launch_fire;
  logic [3:0] n_hit;
  logic [3:0] n_miss;
  logic [8:0] hit_sum;
  logic [8:0] miss_sum;
  logic [7:0] hit_d;
  logic [7:0] miss_d;

`ifdef FRUIT_PAUSE_EN
  assign run = ~pause;
`else
  assign run = 1'b1;
`endif

  // Lowest-index idle slot wins, so scan from the top down.
  always_comb begin
    launch_idx = '0;
    any_idle   = 1'b0;
    for (int i = NUM_FRUITS - 1; i >= 0; i--) begin
      if (state_q[i] == IDLE) begin
        launch_idx = 3'(i);
        any_idle   = 1'b1;
      end
    end
  end

  assign launch_ready = any_idle & run;
  assign launch_fire  = launch_valid & launch_ready;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_FRUITS; i++) begin
        state_q[i] <= IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        vx_q[i]    <= '0;
        vy_q[i]    <= '0;
      end
      slice_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      for (int i = 0; i < NUM_FRUITS; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        vx_q[i]    <= vx_d[i];
        vy_q[i]    <= vy_d[i];
      end
      slice_pulse <= (n_hit != '0);
      miss_pulse  <= (n_miss != '0);
      hit_count   <= hit_d;
      miss_count  <= miss_d;
    end
  end

  always_comb begin
    logic signed [10:0] nx;
    logic signed [10:0] ny;
    logic signed [10:0] x_lo;
    logic signed [10:0] x_hi;
    logic signed [10:0] y_lo;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] vy_base;
    logic signed [10:0] vy_w;
    logic               hit;
    logic               exiting;
    n_hit   = '0;
    n_miss  = '0;
    nx      = '0;
    ny      = '0;
    x_lo    = '0;
    x_hi    = '0;
    y_lo    = '0;
    dx      = '0;
    dy      = '0;
    vy_base = '0;
    vy_w    = '0;
    hit     = 1'b0;
    exiting = 1'b0;
    for (int i = 0; i < NUM_FRUITS; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      vx_d[i]    = vx_q[i];
      vy_d[i]    = vy_q[i];
      if (run) begin
        if (state_q[i] == IDLE) begin
          if (launch_fire && launch_idx == 3'(i)) begin
            state_d[i] = FLYING;
            x_d[i]     = launch_x;
            y_d[i]     = 10'(Y_MAX - SIZE);
            vx_d[i]    = launch_vx;
            vy_d[i]    = launch_vy;
          end
        end else begin
          nx      = $signed({1'b0, x_q[i]}) + 11'(vx_q[i]);
          ny      = $signed({1'b0, y_q[i]}) + 11'(vy_q[i]);
          x_lo    = nx - SZ;
          x_hi    = nx + SZ;
          y_lo    = ny - SZ;
          dx      = $signed({1'b0, x_q[i]}) - $signed({1'b0, blade_x});
          dy      = $signed({1'b0, y_q[i]}) - $signed({1'b0, blade_y});
          hit     = blade_valid && (state_q[i] == FLYING) &&
                    (dx >= -SZ) && (dx <= SZ) && (dy >= -SZ) && (dy <= SZ);
          exiting = !vy_q[i][VEL_W-1] && (vy_q[i] != '0) && ((ny + SZ) >= YMX);
          vy_base = 11'(vy_q[i]);
          if (hit) begin
            state_d[i] = SLICED;
            n_hit      = n_hit + 4'd1;
          end
          // A slice on the exit edge keeps the fruit alive one more frame as SLICED.
          if (exiting) begin
            if (!hit) begin
              state_d[i] = IDLE;
              if (state_q[i] == FLYING) n_miss = n_miss + 4'd1;
            end
          end else begin
            if (x_lo[10]) begin
              x_d[i]  = 10'(SIZE);
              vx_d[i] = -vx_q[i];
            end else if (x_hi > XMX) begin
              x_d[i]  = 10'(X_MAX - SIZE);
              vx_d[i] = -vx_q[i];
            end else begin
              x_d[i] = nx[9:0];
            end
            if (y_lo[10]) begin
              y_d[i]  = 10'(SIZE);
              vy_base = '0;
            end else begin
              y_d[i] = ny[9:0];
            end
          end
          vy_w    = vy_base + GRV;
          vy_d[i] = (vy_w > VMX) ? VMX[VEL_W-1:0] : vy_w[VEL_W-1:0];
          if (hit) vx_d[i] = '0;
        end
      end
    end
    hit_sum  = {1'b0, hit_count} + 9'(n_hit);
    miss_sum = {1'b0, miss_count} + 9'(n_miss);
    hit_d    = hit_sum[8] ? 8'hFF : hit_sum[7:0];
    miss_d   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
  end

  assign fruitS = 10'(SIZE);

  for (genvar g = 0; g < NUM_FRUITS; g++) begin : g_out
    assign fruitX[10*g +: 10] = x_q[g];
    assign fruitY[10*g +: 10] = y_q[g];
    assign fruit_active[g]    = (state_q[g] != IDLE);
    assign fruit_sliced[g]    = (state_q[g] == SLICED);
  end

endmodule
